// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one synchronous sprite ROM read port between the P1 and P2 fetch paths.
// A tag shift register steers each returned word to its requester; per-frame stall counters track starvation.
module sprite_rom_arbiter #(
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 24,
   parameter int ROM_LATENCY = 2,
   parameter int STALL_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               p1_req,
   input  logic [ADDR_W-1:0]  p1_addr,
   output logic               p1_gnt,
   output logic               p1_rvalid,
   output logic [DATA_W-1:0]  p1_rdata,
   input  logic               p2_req,
   input  logic [ADDR_W-1:0]  p2_addr,
   output logic               p2_gnt,
   output logic               p2_rvalid,
   output logic [DATA_W-1:0]  p2_rdata,
   output logic               rom_rd,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [DATA_W-1:0]  rom_rdata,
   output logic [STALL_W-1:0] p1_stalls,
   output logic [STALL_W-1:0] p2_stalls
);

   localparam int   TAG_DEPTH = ROM_LATENCY + 1;
   localparam logic PLAYER_P1 = 1'b0;
   localparam logic PLAYER_P2 = 1'b1;

   // Handshake: a read is accepted in exactly the cycle where req and gnt are both high.
   logic                 last_grant_q;
   logic                 gnt_p1;
   logic                 gnt_p2;
   logic                 any_gnt;

   logic                 rom_rd_q;
   logic [ADDR_W-1:0]    rom_addr_q;
   logic [ADDR_W-1:0]    rom_addr_d;

   logic [TAG_DEPTH-1:0] tag_vld_q;
   logic [TAG_DEPTH-1:0] tag_id_q;
   logic                 ret_vld;
   logic                 ret_id;

   logic                 p1_rvalid_q;
   logic                 p2_rvalid_q;
   logic [DATA_W-1:0]    p1_rdata_q;
   logic [DATA_W-1:0]    p2_rdata_q;

   logic [STALL_W-1:0]   p1_stalls_q;
   logic [STALL_W-1:0]   p1_stalls_d;
   logic [STALL_W-1:0]   p2_stalls_q;
   logic [STALL_W-1:0]   p2_stalls_d;

   // P1 wins a contended cycle only when P2 was the last player served.
   always_comb begin
      gnt_p1 = 1'b0;
      gnt_p2 = 1'b0;
      if (!reset) begin
         if (p1_req && (!p2_req || last_grant_q == PLAYER_P2)) begin
            gnt_p1 = 1'b1;
         end else if (p2_req) begin
            gnt_p2 = 1'b1;
         end
      end
   end

   assign any_gnt = gnt_p1 | gnt_p2;

   always_comb begin
      rom_addr_d = rom_addr_q;
      if (gnt_p1) begin
         rom_addr_d = p1_addr;
      end else if (gnt_p2) begin
         rom_addr_d = p2_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= PLAYER_P2;
         rom_rd_q     <= 1'b0;
         rom_addr_q   <= '0;
      end else begin
         if (any_gnt) begin
            last_grant_q <= gnt_p2;
         end
         rom_rd_q   <= any_gnt;
         rom_addr_q <= rom_addr_d;
      end
   end

   // Stage k holds the tag of the read issued k cycles ago; the last stage lines up with rom_rdata.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         tag_vld_q <= {tag_vld_q[TAG_DEPTH-2:0], any_gnt};
         tag_id_q  <= {tag_id_q[TAG_DEPTH-2:0], gnt_p2};
      end
   end

   assign ret_vld = tag_vld_q[ROM_LATENCY];
   assign ret_id  = tag_id_q[ROM_LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         p1_rvalid_q <= 1'b0;
         p2_rvalid_q <= 1'b0;
         p1_rdata_q  <= '0;
         p2_rdata_q  <= '0;
      end else begin
         p1_rvalid_q <= ret_vld && (ret_id == PLAYER_P1);
         p2_rvalid_q <= ret_vld && (ret_id == PLAYER_P2);
         if (ret_vld && (ret_id == PLAYER_P1)) begin
            p1_rdata_q <= rom_rdata;
         end
         if (ret_vld && (ret_id == PLAYER_P2)) begin
            p2_rdata_q <= rom_rdata;
         end
      end
   end

   // frame_start beats a same-cycle increment; counters stick at all-ones.
   always_comb begin
      p1_stalls_d = p1_stalls_q;
      p2_stalls_d = p2_stalls_q;
      if (frame_start) begin
         p1_stalls_d = '0;
         p2_stalls_d = '0;
      end else begin
         if (p1_req && !gnt_p1 && (p1_stalls_q != {STALL_W{1'b1}})) begin
            p1_stalls_d = p1_stalls_q + STALL_W'(1);
         end
         if (p2_req && !gnt_p2 && (p2_stalls_q != {STALL_W{1'b1}})) begin
            p2_stalls_d = p2_stalls_q + STALL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p1_stalls_q <= '0;
         p2_stalls_q <= '0;
      end else begin
         p1_stalls_q <= p1_stalls_d;
         p2_stalls_q <= p2_stalls_d;
      end
   end

   assign p1_gnt    = gnt_p1;
   assign p2_gnt    = gnt_p2;
   assign p1_rvalid = p1_rvalid_q;
   assign p2_rvalid = p2_rvalid_q;
   assign p1_rdata  = p1_rdata_q;
   assign p2_rdata  = p2_rdata_q;
   assign rom_rd    = rom_rd_q;
   assign rom_addr  = rom_addr_q;
   assign p1_stalls = p1_stalls_q;
   assign p2_stalls = p2_stalls_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: two-cycle ROM model returning addr+0x100000.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_sprite_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_start;
   logic        p1_req, p2_req;
   logic [14:0] p1_addr, p2_addr;
   logic        p1_gnt, p2_gnt;
   logic        p1_rvalid, p2_rvalid;
   logic [23:0] p1_rdata, p2_rdata;
   logic        rom_rd;
   logic [14:0] rom_addr;
   logic [23:0] rom_rdata;
   logic [7:0]  p1_stalls, p2_stalls;

   int errors = 0;
   int checks = 0;

   logic [14:0] rom_a1, rom_a2;

   sprite_rom_arbiter #(
      .ADDR_W(15), .DATA_W(24), .ROM_LATENCY(2), .STALL_W(8)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt),
      .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .p2_req(p2_req), .p2_addr(p2_addr), .p2_gnt(p2_gnt),
      .p2_rvalid(p2_rvalid), .p2_rdata(p2_rdata),
      .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .p1_stalls(p1_stalls), .p2_stalls(p2_stalls)
   );

   always #5 clk = ~clk;

   // Two register stages: data for the rom_addr seen in cycle T appears in cycle T+2.
   always_ff @(posedge clk) begin
      rom_a1 <= rom_addr;
      rom_a2 <= rom_a1;
   end
   assign rom_rdata = 24'h100000 + {9'd0, rom_a2};

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; frame_start = 1'b0;
      p1_req = 1'b1; p2_req = 1'b1;
      p1_addr = 15'h0020; p2_addr = 15'h0040;

      // 1: reset with both requests high
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         next_cyc();
         @(negedge clk);
         check("rst_p1_gnt", p1_gnt, 0);
         check("rst_p2_gnt", p2_gnt, 0);
         check("rst_rom_rd", rom_rd, 0);
         check("rst_rom_addr", rom_addr, 0);
         check("rst_p1_rvalid", p1_rvalid, 0);
         check("rst_p2_rvalid", p2_rvalid, 0);
         check("rst_p1_rdata", p1_rdata, 0);
         check("rst_p2_rdata", p2_rdata, 0);
         check("rst_p1_stalls", p1_stalls, 0);
         check("rst_p2_stalls", p2_stalls, 0);
      end
      next_cyc(); reset = 1'b0;
      @(negedge clk);
      check("rel_p1_gnt", p1_gnt, 1);
      check("rel_p2_gnt", p2_gnt, 0);
      next_cyc(); p1_req = 1'b0; p2_req = 1'b0;
      @(negedge clk);
      check("rel_rom_rd", rom_rd, 1);
      check("rel_rom_addr", rom_addr, 32'h0020);
      check("rel_p2_stalls", p2_stalls, 1);
      next_cyc(); next_cyc(); next_cyc();
      @(negedge clk);
      check("rel_p1_rvalid", p1_rvalid, 1);
      check("rel_p1_rdata", p1_rdata, 32'h100020);
      next_cyc(); next_cyc();

      // 2: single P1 read, latency 4
      next_cyc(); p1_req = 1'b1; p1_addr = 15'h0010;
      @(negedge clk);
      check("p1only_gnt", p1_gnt, 1);
      check("p1only_p2_gnt", p2_gnt, 0);
      next_cyc(); p1_req = 1'b0;
      @(negedge clk);
      check("p1only_rom_rd", rom_rd, 1);
      check("p1only_rom_addr", rom_addr, 32'h0010);
      next_cyc();
      @(negedge clk);
      check("p1only_rom_rd_idle", rom_rd, 0);
      check("p1only_rom_addr_hold", rom_addr, 32'h0010);
      next_cyc();
      @(negedge clk);
      check("p1only_rvalid_early", p1_rvalid, 0);
      next_cyc();
      @(negedge clk);
      check("p1only_rvalid", p1_rvalid, 1);
      check("p1only_rdata", p1_rdata, 32'h100010);
      check("p1only_p2_rvalid", p2_rvalid, 0);
      next_cyc();
      @(negedge clk);
      check("p1only_rvalid_drop", p1_rvalid, 0);
      check("p1only_rdata_hold", p1_rdata, 32'h100010);

      // 3: sustained contention after a reset pulse
      next_cyc(); reset = 1'b1;
      for (int k = 0; k < 12; k++) begin
         next_cyc();
         reset = 1'b0;
         if (k < 8) begin
            p1_req = 1'b1; p2_req = 1'b1;
            p1_addr = 15'(32'h0100 + (k + 1) / 2);
            p2_addr = 15'(32'h0200 + k / 2);
         end else begin
            p1_req = 1'b0; p2_req = 1'b0;
         end
         @(negedge clk);
         if (k < 8) begin
            check("rr_p1_gnt", p1_gnt, (k % 2 == 0) ? 1 : 0);
            check("rr_p2_gnt", p2_gnt, (k % 2 == 1) ? 1 : 0);
         end
         check("rr_p1_rvalid", p1_rvalid, (k >= 4 && (k - 4) % 2 == 0) ? 1 : 0);
         check("rr_p2_rvalid", p2_rvalid, (k >= 4 && (k - 4) % 2 == 1) ? 1 : 0);
         if (k >= 4 && (k - 4) % 2 == 0) check("rr_p1_rdata", p1_rdata, 32'h100100 + (k - 4) / 2);
         if (k >= 4 && (k - 4) % 2 == 1) check("rr_p2_rdata", p2_rdata, 32'h100200 + (k - 4) / 2);
      end
      check("rr_p1_stalls", p1_stalls, 4);
      check("rr_p2_stalls", p2_stalls, 4);

      // 4: saturation under 600 cycles of contention
      next_cyc(); frame_start = 1'b1;
      for (int k = 0; k < 600; k++) begin
         next_cyc();
         frame_start = 1'b0;
         p1_req = 1'b1; p2_req = 1'b1;
         p1_addr = 15'h0300; p2_addr = 15'h0400;
         @(negedge clk);
         if (k == 0) begin
            check("sat_clear_p1", p1_stalls, 0);
            check("sat_clear_p2", p2_stalls, 0);
         end
         if (k == 508) begin
            check("sat_p1_254", p1_stalls, 254);
            check("sat_p2_254", p2_stalls, 254);
         end
         if (k == 510) begin
            check("sat_p1_255", p1_stalls, 255);
            check("sat_p2_255", p2_stalls, 255);
         end
      end
      next_cyc(); p1_req = 1'b0; p2_req = 1'b0;
      @(negedge clk);
      check("sat_p1_nowrap", p1_stalls, 255);
      check("sat_p2_nowrap", p2_stalls, 255);

      // 5: frame_start coincident with a stall
      next_cyc(); p1_req = 1'b1; p2_req = 1'b1; frame_start = 1'b1;
      @(negedge clk);
      check("fs_p1_gnt", p1_gnt, 1);
      next_cyc(); frame_start = 1'b0;
      @(negedge clk);
      check("fs_p1_stalls", p1_stalls, 0);
      check("fs_p2_stalls", p2_stalls, 0);
      next_cyc(); p1_req = 1'b0; p2_req = 1'b0;
      @(negedge clk);
      check("fs_p1_inc", p1_stalls, 1);
      check("fs_p2_hold", p2_stalls, 0);
      for (int i = 0; i < 6; i++) next_cyc();

      // 6: reset right after a P1 grant drops that read
      p1_req = 1'b1; p1_addr = 15'h0030;
      @(negedge clk);
      check("rdrop_gnt", p1_gnt, 1);
      next_cyc(); reset = 1'b1; p1_req = 1'b0; p2_req = 1'b1;
      @(negedge clk);
      check("rdrop_p2_gnt_forced", p2_gnt, 0);
      check("rdrop_rom_rd", rom_rd, 1);
      next_cyc(); reset = 1'b0; p1_req = 1'b1; p2_req = 1'b1; p1_addr = 15'h0031;
      @(negedge clk);
      check("rdrop_next_p1_gnt", p1_gnt, 1);
      check("rdrop_next_p2_gnt", p2_gnt, 0);
      check("rdrop_rom_rd_clr", rom_rd, 0);
      check("rdrop_rom_addr_clr", rom_addr, 0);
      check("rdrop_p1_rdata_clr", p1_rdata, 0);
      check("rdrop_p2_stalls_clr", p2_stalls, 0);
      for (int j = 3; j < 6; j++) begin
         next_cyc(); p1_req = 1'b0; p2_req = 1'b0;
         @(negedge clk);
         check("rdrop_no_rvalid", p1_rvalid, 0);
         check("rdrop_rdata_zero", p1_rdata, 0);
      end
      next_cyc();
      @(negedge clk);
      check("rdrop_new_rvalid", p1_rvalid, 1);
      check("rdrop_new_rdata", p1_rdata, 32'h100031);
      check("rdrop_p2_rvalid", p2_rvalid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
